gate_not_probe: RTL and testbench

- Stimulus and response end of a single-input logic gate. It drives the gate's input from a latched bit pattern and samples the gate's output once the drive has settled.
- Checks each sample against the expected inverting (NOT) or buffering response, then reports the error count, the first failing bit index and pass/fail.
- Sits beside the transistor-level gate cells as their self-checking partner, in the same clock domain as the harness that starts it.

---
 rtl/gate_not_probe_pkg.sv | 13 +
 rtl/gate_not_probe_settle_timer.sv | 40 ++++
 rtl/gate_not_probe.sv | 146 ++++++++++++++
 tb/tb_gate_not_probe.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/gate_not_probe_pkg.sv
// Shared definitions for the single-input gate probe family.
// State encodings and the idle drive level of the gate input.
package gate_not_probe_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_DONE   = 2'd2
   } probe_state_e;

   localparam logic IDLE_DRIVE = 1'b0;

endpackage

// File: rtl/gate_not_probe_settle_timer.sv
// Loadable down-counter with a terminal-count flag (cnt == 1).
// Shared by gate probes to time the settle window of each bit.
module probe_settle_timer #(
   parameter int TW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_i,
   input  logic [TW-1:0] load_val_i,
   input  logic          en_i,
   output logic [TW-1:0] cnt_o,
   output logic          tc_o
);

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_d;

   // Load wins over counting; the count stops at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == TW'(1));

endmodule

// File: rtl/gate_not_probe.sv
// Stimulus/response checker for a single-input gate (NOT or buffer).
// Drives one pattern bit per settle window, samples and counts mismatches.
module gate_not_probe
   import gate_not_probe_pkg::*;
#(
   parameter int PATTERN_LEN   = 8,
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 8,
   parameter int IDX_W         = (PATTERN_LEN > 1) ? $clog2(PATTERN_LEN) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [PATTERN_LEN-1:0] pattern,
   input  logic                   invert_expect,
   input  logic                   dut_out,
   output logic                   dut_inp,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [CNT_W-1:0]       err_count,
   output logic [IDX_W-1:0]       first_err_idx,
   output logic                   err_valid
);

   localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [TW-1:0]    SETTLE_LD = TW'(SETTLE_CYCLES);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PATTERN_LEN - 1);
   localparam logic [CNT_W-1:0] ERR_MAX   = {CNT_W{1'b1}};

   probe_state_e           state_q;
   logic [PATTERN_LEN-1:0] pattern_q;
   logic                   inv_q;
   logic [IDX_W-1:0]       idx_q;
   logic                   dut_inp_q;
   logic                   done_q;
   logic                   pass_q;
   logic [CNT_W-1:0]       err_q;
   logic [IDX_W-1:0]       first_q;
   logic                   ev_q;

   logic                   accept;
   logic                   last_bit;
   logic                   exp_bit;
   logic                   mis;
   logic [CNT_W-1:0]       err_inc;
   logic [IDX_W-1:0]       idx_nxt;
   logic                   tmr_load;
   logic                   tmr_en;
   logic                   tc;
   logic [TW-1:0]          tmr_cnt;

   // Sample decode: expected response, mismatch and saturated error count.
   always_comb begin
      accept   = (state_q == ST_IDLE) && start;
      last_bit = (idx_q == LAST_IDX);
      idx_nxt  = idx_q + 1'b1;
      exp_bit  = pattern_q[idx_q] ^ inv_q;
      // X/Z on the gate output must count as a failure.
      mis      = (dut_out !== exp_bit);
      err_inc  = (err_q == ERR_MAX) ? err_q : err_q + 1'b1;
      tmr_en   = (state_q == ST_SETTLE);
      tmr_load = accept || (tmr_en && tc && !last_bit);
   end

   probe_settle_timer #(
      .TW(TW)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (SETTLE_LD),
      .en_i       (tmr_en),
      .cnt_o      (tmr_cnt),
      .tc_o       (tc)
   );

   // Run control, gate drive and error accounting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pattern_q <= '0;
         inv_q     <= 1'b0;
         idx_q     <= '0;
         dut_inp_q <= IDLE_DRIVE;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         err_q     <= '0;
         first_q   <= '0;
         ev_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  pattern_q <= pattern;
                  inv_q     <= invert_expect;
                  idx_q     <= '0;
                  dut_inp_q <= pattern[0];
                  err_q     <= '0;
                  first_q   <= '0;
                  ev_q      <= 1'b0;
                  pass_q    <= 1'b0;
                  state_q   <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (tc) begin
                  if (mis) begin
                     err_q <= err_inc;
                     if (!ev_q) begin
                        first_q <= idx_q;
                        ev_q    <= 1'b1;
                     end
                  end
                  if (last_bit) begin
                     // Final bit's result is folded into pass here.
                     pass_q  <= !mis && (err_q == '0);
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     idx_q     <= idx_nxt;
                     dut_inp_q <= pattern_q[idx_nxt];
                  end
               end
            end
            ST_DONE: begin
               dut_inp_q <= IDLE_DRIVE;
               state_q   <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign dut_inp       = dut_inp_q;
   assign busy          = (state_q == ST_SETTLE);
   assign done          = done_q;
   assign pass          = pass_q;
   assign err_count     = err_q;
   assign first_err_idx = first_q;
   assign err_valid     = ev_q;

endmodule

// File: tb/tb_gate_not_probe.sv
// Directed bench for gate_not_probe with a behavioural gate model.
// Second instance uses a 2-bit error counter for saturation.
module tb_gate_not_probe;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       start = 1'b0;
   logic [7:0] pattern = 8'h00;
   logic       inv = 1'b0;
   logic       dut_out;
   int         mode = 0;
   logic       dut_inp, busy, done, pass, err_valid;
   logic [7:0] err_count;
   logic [2:0] first_err_idx;

   logic       start1 = 1'b0;
   logic       dut_inp1, busy1, done1, pass1, err_valid1;
   logic [1:0] err_count1;
   logic [2:0] first_err_idx1;

   int nvec = 0;
   int nmis = 0;

   always #5 clk = ~clk;

   // mode 0: NOT gate, 1: stuck 1, 2: stuck 0
   assign dut_out = (mode == 0) ? ~dut_inp : (mode == 1) ? 1'b1 : 1'b0;

   gate_not_probe u0 (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .pattern       (pattern),
      .invert_expect (inv),
      .dut_out       (dut_out),
      .dut_inp       (dut_inp),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .err_count     (err_count),
      .first_err_idx (first_err_idx),
      .err_valid     (err_valid)
   );

   gate_not_probe #(.CNT_W(2)) u1 (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start1),
      .pattern       (8'h00),
      .invert_expect (1'b1),
      .dut_out       (1'b0),
      .dut_inp       (dut_inp1),
      .busy          (busy1),
      .done          (done1),
      .pass          (pass1),
      .err_count     (err_count1),
      .first_err_idx (first_err_idx1),
      .err_valid     (err_valid1)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic run(input string tag, input int md, input logic [7:0] pat,
                      input logic iv, input bit disturb,
                      input int e_cnt, input int e_first, input logic e_ev,
                      input logic e_pass);
      int lat;
      int extra;
      lat = 0;
      extra = 0;
      @(negedge clk);
      mode    = md;
      pattern = pat;
      inv     = iv;
      start   = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk({tag, "_busy"}, 32'(busy), 1);
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (disturb && n == 5) begin
            start   = 1'b1;
            pattern = ~pat;
            inv     = ~iv;
         end
         if (disturb && n == 6) start = 1'b0;
         if (done) begin
            lat = n;
            break;
         end
      end
      chk({tag, "_lat"}, lat, 16);
      chk({tag, "_cnt"}, 32'(err_count), e_cnt);
      chk({tag, "_first"}, 32'(first_err_idx), e_first);
      chk({tag, "_ev"}, 32'(err_valid), 32'(e_ev));
      chk({tag, "_pass"}, 32'(pass), 32'(e_pass));
      @(posedge clk);
      #1;
      chk({tag, "_pulse"}, 32'(done), 0);
      chk({tag, "_idle_drv"}, 32'(dut_inp), 0);
      for (int n = 0; n < 20; n++) begin
         @(posedge clk);
         #1;
         if (done || busy) extra++;
      end
      chk({tag, "_extra"}, extra, 0);
      chk({tag, "_hold"}, 32'(err_count), e_cnt);
   endtask

   initial begin
      int lat1;
      #1;
      chk("rst_async_busy", 32'(busy), 0);
      chk("rst_async_inp", 32'(dut_inp), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_done", 32'(done), 0);
      chk("rst_pass", 32'(pass), 0);
      chk("rst_cnt", 32'(err_count), 0);
      chk("rst_first", 32'(first_err_idx), 0);
      chk("rst_ev", 32'(err_valid), 0);

      run("t1_not", 0, 8'hA5, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
      run("t2_buf", 0, 8'h0F, 1'b0, 1'b0, 8, 0, 1'b1, 1'b0);
      run("t3_stk1", 1, 8'b0000_0110, 1'b1, 1'b0, 2, 1, 1'b1, 1'b0);

      // saturation on the 2-bit counter instance
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      lat1 = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done1) begin
            lat1 = 1;
            break;
         end
      end
      chk("t4_done", lat1, 1);
      chk("t4_sat", 32'(err_count1), 3);
      chk("t4_pass", 32'(pass1), 0);
      chk("t4_ev", 32'(err_valid1), 1);
      chk("t4_first", 32'(first_err_idx1), 0);

      run("t5_ign", 1, 8'b0000_0110, 1'b1, 1'b1, 2, 1, 1'b1, 1'b0);

      // async reset mid-run
      @(negedge clk);
      mode    = 1;
      pattern = 8'h00;
      inv     = 1'b0;
      start   = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int n = 1; n <= 7; n++) @(posedge clk);
      #2;
      chk("t6_pre_cnt", 32'(err_count), 3);
      rst_n = 1'b0;
      #1;
      chk("t6_busy", 32'(busy), 0);
      chk("t6_cnt", 32'(err_count), 0);
      chk("t6_ev", 32'(err_valid), 0);
      chk("t6_first", 32'(first_err_idx), 0);
      chk("t6_inp", 32'(dut_inp), 0);
      chk("t6_pass", 32'(pass), 0);
      chk("t6_done", 32'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run("t6_fresh", 0, 8'hA5, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
